// File: rtl/inst_fetch_wb_pkg.sv
// Shared types and constants for the instruction-fetch Wishbone interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_wb_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [31:0] NopInst     = 32'h0000_0000;
  localparam logic [3:0]  WB_SEL_WORD = 4'hF;

endpackage

// File: rtl/inst_fetch_wb_fetch_timeout_cnt.sv
// Ack-wait counter: clears on BUSY entry, counts BUSY cycles, flags the terminal count.
// Latency: expired_o is combinational from the registered count.
// Backpressure: none; the count saturates at 8'hFF instead of wrapping.
module inst_fetch_wb_fetch_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] Limit = 8'(LIMIT);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear on entry, otherwise advance once per waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == Limit);

endmodule

// File: rtl/inst_fetch_wb.sv
// IF-stage Wishbone master: one classic read per instruction, word + PC handed to IF/ID.
// Latency: 2 cycles per fetch with a zero-wait slave; each ack wait cycle adds one stall cycle.
// Backpressure: stallreq_o holds the pipeline during the bus cycle; stall_i parks the word in HOLD.
// Optional ack timeout enabled by defining FETCH_TIMEOUT_EN.
module inst_fetch_wb
  import inst_fetch_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  input  logic [31:0] pc_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        fetch_err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  rbuf_q, rbuf_d;
  logic         cyc_q, cyc_d;
  logic         timeout_hit;
  logic         stall_any;

  assign stall_any = |stall_i;

`ifdef FETCH_TIMEOUT_EN
  logic cnt_expired;
  logic busy_entry;
  logic err_q;

  assign busy_entry = (state_q == IDLE) && ce_i && !flush_i;

  inst_fetch_wb_fetch_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (busy_entry),
    .en_i     (state_q == BUSY),
    .expired_o(cnt_expired)
  );

  // An ack or a flush in the terminal cycle takes priority over the timeout
  assign timeout_hit = cnt_expired && !wb_ack_i && !flush_i;

  // One-cycle error pulse in the cycle after the abandoned bus cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign fetch_err_o = err_q;
`else
  // Limit only matters with the counter; folded in so it is still referenced
  localparam bit TimeoutLimitSet = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
  assign fetch_err_o = 1'b0 & TimeoutLimitSet;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush aborts everything, ack ends BUSY, downstream stall parks in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ce_i && !flush_i) state_d = BUSY;
      BUSY: begin
        if (flush_i)          state_d = IDLE;
        else if (wb_ack_i)    state_d = stall_any ? HOLD : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      HOLD: if (flush_i || !stall_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and bus/buffer next values; returned word bypasses the buffer in the ack cycle
  always_comb begin
    stallreq_o = 1'b0;
    if_inst_o  = NopInst;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    rbuf_d     = rbuf_q;
    unique case (state_q)
      IDLE: begin
        stallreq_o = ce_i && !flush_i;
        if (ce_i && !flush_i) begin
          adr_d = pc_i;
          cyc_d = 1'b1;
        end
      end
      BUSY: begin
        if (flush_i) begin
          cyc_d = 1'b0;
        end else if (wb_ack_i) begin
          cyc_d     = 1'b0;
          rbuf_d    = wb_dat_i;
          if_inst_o = wb_dat_i;
        end else if (timeout_hit) begin
          cyc_d = 1'b0;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      HOLD: begin
        if (!flush_i) if_inst_o = rbuf_q;
      end
      default: cyc_d = 1'b0;
    endcase
  end

  // Bus address, cycle strobe and read buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q  <= ZeroWord;
      cyc_q  <= 1'b0;
      rbuf_q <= ZeroWord;
    end else begin
      adr_q  <= adr_d;
      cyc_q  <= cyc_d;
      rbuf_q <= rbuf_d;
    end
  end

  assign wb_adr_o = adr_q;
  assign if_pc_o  = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = WB_SEL_WORD;

endmodule

// File: tb/tb_inst_fetch_wb.sv
// Bench for inst_fetch_wb: Wishbone slave model plus scoreboard of expected fetches.
// Latency: n/a.
// Backpressure: stall_i driven by the bench; slave ack delay programmable.
module tb_inst_fetch_wb;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        stallreq_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        fetch_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;

  inst_fetch_wb #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .ce_i(ce_i), .pc_i(pc_i), .stall_i(stall_i),
    .flush_i(flush_i), .stallreq_o(stallreq_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .fetch_err_o(fetch_err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   ack_dly = 0;
  bit   no_ack  = 1'b0;
  int   wcnt    = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h3000_0000: return 32'h3C01_0000;
      32'h3000_0004: return 32'h3421_0001;
      32'h3000_0008: return 32'h2402_0005;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: ack after ack_dly waiting cycles of an active cycle
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && !no_ack) begin
      if (wcnt == ack_dly) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rom(wb_adr_o);
      end else begin
        wb_ack_i = 1'b0;
      end
      wcnt++;
    end else begin
      wb_ack_i = 1'b0;
      wcnt = 0;
    end
  end

  // Scoreboard: every accepted ack must present the next expected word and PC
  always @(negedge clk) begin
    #1;
    if (rst_n && wb_cyc_o && wb_ack_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_fetch", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("if_inst", if_inst_o, mon_e.inst);
        check_eq("if_pc", if_pc_o, mon_e.pc);
        check_eq("stallreq_at_ack", 32'(stallreq_o), 32'd0);
      end
    end
  end

  // Called at posedge+2 of an IDLE cycle; returns at posedge+2 after the ack cycle
  task automatic do_fetch(input logic [31:0] pc, input int dly,
                          output int ncyc, output int nstall, output bit pc_ok);
    bit got;
    pc_i    = pc;
    ce_i    = 1'b1;
    ack_dly = dly;
    exp_q.push_back({pc, rom(pc)});
    ncyc = 0; nstall = 0; pc_ok = 1'b1; got = 1'b0;
    do begin
      @(negedge clk); #2;
      ncyc++;
      if (ncyc == 1) check_eq("idle_stallreq", 32'(stallreq_o), 32'd1);
      if (wb_cyc_o && stallreq_o) nstall++;
      if (wb_cyc_o && (if_pc_o !== pc)) pc_ok = 1'b0;
      got = wb_cyc_o && wb_ack_i;
      @(posedge clk); #2;
      ce_i = 1'b0;
    end while (!got && ncyc < 50);
    if (!got) check_eq("fetch_done", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int nc, ns, nerr, nterm;
    bit pc_ok;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rst_adr", wb_adr_o, 32'd0);
    check_eq("rst_if_inst", if_inst_o, 32'd0);
    check_eq("rst_stallreq", 32'(stallreq_o), 32'd0);
    check_eq("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    check_eq("sel_const", 32'(wb_sel_o), 32'hF);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Zero-wait fetches: 2-cycle cadence, no BUSY stall cycles
    do_fetch(32'h3000_0000, 0, nc, ns, pc_ok);
    check_eq("zw_cycles", 32'(nc), 32'd2);
    check_eq("zw_stall", 32'(ns), 32'd0);

    // Three wait states: exactly three stalled BUSY cycles, PC stable
    do_fetch(32'h3000_0004, 3, nc, ns, pc_ok);
    check_eq("ws_cycles", 32'(nc), 32'd5);
    check_eq("ws_stall", 32'(ns), 32'd3);
    check_eq("ws_pc_stable", 32'(pc_ok), 32'd1);

    // Downstream stall at ack: word held in HOLD until release
    stall_i = 6'b000011;
    do_fetch(32'h3000_0008, 0, nc, ns, pc_ok);
    check_eq("hold_cycles", 32'(nc), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check_eq("hold_inst", if_inst_o, 32'h2402_0005);
      check_eq("hold_stallreq", 32'(stallreq_o), 32'd0);
      @(posedge clk); #2;
    end
    stall_i = 6'b000000;
    @(negedge clk); #2;
    check_eq("release_inst", if_inst_o, 32'h2402_0005);
    check_eq("release_cyc", 32'(wb_cyc_o), 32'd0);
    @(posedge clk); #2;
    @(negedge clk); #2;
    check_eq("after_release_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("after_release_inst", if_inst_o, 32'd0);
    @(posedge clk); #2;

    // Flush in BUSY with a coincident ack
    pc_i = 32'h3000_0010; ce_i = 1'b1; ack_dly = 0;
    @(posedge clk); #2;
    ce_i = 1'b0; flush_i = 1'b1;
    @(negedge clk); #2;
    check_eq("flush_ack_seen", 32'(wb_ack_i), 32'd1);
    check_eq("flush_inst", if_inst_o, 32'd0);
    check_eq("flush_stallreq", 32'(stallreq_o), 32'd0);
    @(posedge clk); #2;
    flush_i = 1'b0;
    check_eq("flush_cyc_drop", 32'(wb_cyc_o), 32'd0);
    do_fetch(32'h0000_0020, 0, nc, ns, pc_ok);
    check_eq("post_flush_cycles", 32'(nc), 32'd2);
    check_eq("post_flush_pc", wb_adr_o, 32'h0000_0020);

`ifdef FETCH_TIMEOUT_EN
    // Timeout with no ack: four stalled cycles, terminal cycle, then one error pulse
    no_ack = 1'b1;
    pc_i = 32'h0000_0040; ce_i = 1'b1;
    @(posedge clk); #2;
    ce_i = 1'b0;
    ns = 0; nerr = 0; nterm = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      if (wb_cyc_o && stallreq_o) ns++;
      if (wb_cyc_o && !stallreq_o) begin
        nterm++;
        check_eq("to_term_inst", if_inst_o, 32'd0);
      end
      if (fetch_err_o) begin
        nerr++;
        check_eq("to_err_cyc", 32'(wb_cyc_o), 32'd0);
        check_eq("to_err_stallreq", 32'(stallreq_o), 32'd0);
      end
      @(posedge clk); #2;
    end
    check_eq("to_stall_cycles", 32'(ns), 32'd4);
    check_eq("to_term_cycles", 32'(nterm), 32'd1);
    check_eq("to_err_pulses", 32'(nerr), 32'd1);
    no_ack = 1'b0;
`else
    check_eq("no_timeout_err", 32'(fetch_err_o), 32'd0);
`endif

    // Asynchronous reset during BUSY
    no_ack = 1'b1;
    pc_i = 32'h0000_0050; ce_i = 1'b1;
    @(posedge clk); #2;
    ce_i = 1'b0;
    @(negedge clk); #2;
    check_eq("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("arst_stb", 32'(wb_stb_o), 32'd0);
    check_eq("arst_adr", wb_adr_o, 32'd0);
    check_eq("arst_if_pc", if_pc_o, 32'd0);
    check_eq("arst_if_inst", if_inst_o, 32'd0);
    check_eq("arst_stallreq", 32'(stallreq_o), 32'd0);
    check_eq("arst_fetch_err", 32'(fetch_err_o), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    no_ack = 1'b0;
    repeat (2) @(posedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
